// File: rtl/mcpu_intc_pkg.sv
// mcpu_intc_pkg: shared register map and FSM encoding for the MCPU interrupt controller.
package mcpu_intc_pkg;
    localparam logic [2:0] INTC_STATUS  = 3'd0;
    localparam logic [2:0] INTC_ENABLE  = 3'd1;
    localparam logic [2:0] INTC_EDGE    = 3'd2;
    localparam logic [2:0] INTC_CLEAR   = 3'd3;
    localparam logic [2:0] INTC_CURRENT = 3'd4;
    typedef enum logic [1:0] {INTC_IDLE, INTC_PRESENT, INTC_ACK} intc_state_e;
endpackage

// File: rtl/mcpu_intc_prio.sv
// mcpu_intc_prio: lowest-index-wins priority encoder over the eligible interrupt sources.
module mcpu_intc_prio #(
    parameter int NSRC = 16
) (
    input  logic [NSRC-1:0] req_i,
    output logic            any_o,
    output logic [3:0]      idx_o
);
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req_i[i]) idx_o = 4'(i);
    end
endmodule

// File: rtl/mcpu_intc.sv
// mcpu_intc: synchronises peripheral interrupt lines, latches edges, and presents the
// lowest-index eligible source to the core with a pending/clear handshake.
module mcpu_intc
    import mcpu_intc_pkg::*;
#(
    parameter int NSRC  = 16,
    parameter int NSYNC = 2
) (
    input  logic            clkrst_core_clk,
    input  logic            clkrst_core_rst,
    input  logic [NSRC-1:0] int_src,
    output logic            int_pending,
    output logic [3:0]      int_type,
    input  logic            int_clear,
    input  logic [2:0]      mmio_addr,
    input  logic            mmio_re,
    input  logic [3:0]      mmio_we,
    input  logic [31:0]     mmio_wdata,
    output logic [31:0]     mmio_rdata
);
    logic [NSYNC-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0] prev_q, en_q, en_d, edge_q, edge_d, lat_q, lat_d;
    logic [NSRC-1:0] synced, rise, pend, elig, bm, wr, clr;
    logic [31:0] bm32, rd, rdata_q, rdata_d;
    logic [15:0] elig16, ack16;
    logic [3:0] idx, type_q, type_d;
    logic any, pend_q, pend_d;
    intc_state_e state_q, state_d;

    mcpu_intc_prio #(.NSRC(NSRC)) u_prio (.req_i(elig), .any_o(any), .idx_o(idx));

    assign bm32   = {{8{mmio_we[3]}}, {8{mmio_we[2]}}, {8{mmio_we[1]}}, {8{mmio_we[0]}}};
    assign bm     = bm32[NSRC-1:0];
    assign wr     = mmio_wdata[NSRC-1:0] & bm;
    assign synced = sync_q[NSYNC-1];
    // A fresh rise counts as pending in the same cycle so edge and level sources share latency
    assign rise   = synced & ~prev_q & edge_q;
    assign pend   = (edge_q & (lat_q | rise)) | (~edge_q & synced);
    assign elig   = pend & en_q;
    assign elig16 = 16'(elig);
    assign ack16  = 16'(1) << type_q;
    assign en_d   = (mmio_addr == INTC_ENABLE) ? (en_q & ~bm) | wr : en_q;
    assign edge_d = (mmio_addr == INTC_EDGE) ? (edge_q & ~bm) | wr : edge_q;
    assign clr    = ((mmio_addr == INTC_CLEAR) ? wr : '0)
                  | ((state_q == INTC_PRESENT && int_clear) ? ack16[NSRC-1:0] : '0);
    // Set beats clear; changing a source's mode drops whatever it had latched
    assign lat_d  = ((lat_q & ~clr) | rise) & ~(edge_q ^ edge_d);
    assign rd     = (mmio_addr == INTC_STATUS)  ? 32'(pend)
                  : (mmio_addr == INTC_ENABLE)  ? 32'(en_q)
                  : (mmio_addr == INTC_EDGE)    ? 32'(edge_q)
                  : (mmio_addr == INTC_CURRENT) ? {pend_q, 27'b0, type_q}
                  : '0;
    assign rdata_d = mmio_re ? rd : rdata_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        type_d  = type_q;
        case (state_q)
            INTC_IDLE: if (any) begin
                state_d = INTC_PRESENT;
                pend_d  = 1'b1;
                type_d  = idx;
            end
            INTC_PRESENT: if (int_clear) begin
                state_d = INTC_ACK;
                pend_d  = 1'b0;
            end else if (!elig16[type_q]) begin
                state_d = INTC_IDLE;
                pend_d  = 1'b0;
            end
            default: state_d = INTC_IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            en_q    <= '0;
            edge_q  <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
            pend_q  <= 1'b0;
            type_q  <= '0;
            state_q <= INTC_IDLE;
        end else begin
            sync_q  <= {sync_q[NSYNC-2:0], int_src};
            prev_q  <= synced;
            en_q    <= en_d;
            edge_q  <= edge_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            pend_q  <= pend_d;
            type_q  <= type_d;
            state_q <= state_d;
        end
    end

    assign int_pending = pend_q;
    assign int_type    = type_q;
    assign mmio_rdata  = rdata_q;
endmodule

// File: tb/tb_mcpu_intc.sv
// tb_mcpu_intc: register table, directed handshake scenarios and a randomized run
// checked every cycle against a behavioural reference model.
module tb_mcpu_intc;
    localparam int NSYNC = 2;

    logic clk = 0, rst = 1, clr = 0, re = 0;
    logic [15:0] src = 0;
    logic [2:0] addr = 0;
    logic [3:0] we = 0;
    logic [31:0] wdata = 0, d;
    logic int_pending;
    logic [3:0] int_type;
    logic [31:0] rdata;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    mcpu_intc #(.NSRC(16), .NSYNC(NSYNC)) dut (
        .clkrst_core_clk(clk), .clkrst_core_rst(rst), .int_src(src),
        .int_pending(int_pending), .int_type(int_type), .int_clear(clr),
        .mmio_addr(addr), .mmio_re(re), .mmio_we(we), .mmio_wdata(wdata),
        .mmio_rdata(rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synchroniser as a history queue, presentation as flags
    logic [15:0] hist[$];
    logic [15:0] m_en = 0, m_edge = 0, m_lat = 0;
    bit m_pres = 0, m_bub = 0;
    logic m_po = 0;
    logic [3:0] m_type = 0;
    logic [31:0] m_rd = 0;

    always @(posedge clk) begin : model
        logic [15:0] syn, prv, rs, pnd, elig, bm, wv, clrm, ne, ned;
        logic [31:0] rv;
        if (rst) begin
            hist.delete();
            m_en = 0; m_edge = 0; m_lat = 0; m_pres = 0; m_bub = 0;
            m_po = 0; m_type = 0; m_rd = 0;
        end else begin
            syn  = hist.size() >= NSYNC ? hist[NSYNC-1] : 16'h0;
            prv  = hist.size() > NSYNC ? hist[NSYNC] : 16'h0;
            rs   = syn & ~prv & m_edge;
            pnd  = (m_edge & (m_lat | rs)) | (~m_edge & syn);
            elig = pnd & m_en;
            bm   = {{8{we[1]}}, {8{we[0]}}};
            wv   = wdata[15:0] & bm;
            case (addr)
                3'd0: rv = {16'h0, pnd};
                3'd1: rv = {16'h0, m_en};
                3'd2: rv = {16'h0, m_edge};
                3'd4: rv = {m_po, 27'b0, m_type};
                default: rv = 0;
            endcase
            if (re) m_rd = rv;
            ne   = addr == 3'd1 ? (m_en & ~bm) | wv : m_en;
            ned  = addr == 3'd2 ? (m_edge & ~bm) | wv : m_edge;
            clrm = addr == 3'd3 ? wv : 16'h0;
            if (m_bub) m_bub = 0;
            else if (m_pres) begin
                if (clr) begin m_pres = 0; m_bub = 1; clrm[m_type] = 1'b1; end
                else if (!elig[m_type]) m_pres = 0;
            end else if (elig != 0) begin
                m_pres = 1;
                for (int i = 15; i >= 0; i--) if (elig[i]) m_type = 4'(i);
            end
            m_lat  = ((m_lat & ~clrm) | rs) & ~(m_edge ^ ned);
            m_en   = ne;
            m_edge = ned;
            m_po   = m_pres;
            hist.push_front(src);
            if (hist.size() > NSYNC + 1) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("model_pending", int_pending, m_po);
        chk("model_type", int_type, m_type);
        chk("model_rdata", rdata, m_rd);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic reset_dut();
        src = 0; clr = 0; re = 0; we = 0; rst = 1;
        cyc(1);
        rst = 0;
    endtask
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] v, input logic [3:0] w);
        addr = a; we = w; wdata = v;
        cyc(1);
        we = 0;
    endtask
    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
        addr = a; re = 1;
        cyc(1);
        re = 0;
        v = rdata;
    endtask
    task automatic pulse(input logic [15:0] m);
        src = src | m;
        cyc(1);
        src = src & ~m;
    endtask
    task automatic ack();
        clr = 1;
        cyc(1);
        clr = 0;
    endtask

    typedef struct { logic [2:0] a; logic [3:0] w; logic [31:0] v; logic [31:0] exp; } vec_t;
    vec_t tv[14];

    initial begin
        tv[0]  = '{3'd1, 4'hf, 32'hFFFF_FFFF, 32'h0000_FFFF};
        tv[1]  = '{3'd1, 4'h1, 32'h0000_0000, 32'h0000_FF00};
        tv[2]  = '{3'd1, 4'h2, 32'h0000_1234, 32'h0000_1200};
        tv[3]  = '{3'd1, 4'hc, 32'hFFFF_FFFF, 32'h0000_1200};
        tv[4]  = '{3'd2, 4'h3, 32'h0000_A5A5, 32'h0000_A5A5};
        tv[5]  = '{3'd2, 4'h1, 32'h0000_00FF, 32'h0000_A5FF};
        tv[6]  = '{3'd3, 4'hf, 32'h0000_FFFF, 32'h0000_0000};
        tv[7]  = '{3'd5, 4'hf, 32'h1234_5678, 32'h0000_0000};
        tv[8]  = '{3'd6, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tv[9]  = '{3'd7, 4'hf, 32'hFFFF_FFFF, 32'h0000_0000};
        tv[10] = '{3'd0, 4'hf, 32'h0000_FFFF, 32'h0000_0000};
        tv[11] = '{3'd4, 4'hf, 32'hFFFF_FFFF, 32'h0000_0000};
        tv[12] = '{3'd2, 4'h3, 32'h0000_0000, 32'h0000_0000};
        tv[13] = '{3'd1, 4'h3, 32'h0000_0000, 32'h0000_0000};

        reset_dut();
        chk("reset_pending", int_pending, 0);
        chk("reset_type", int_type, 0);
        chk("reset_rdata", rdata, 0);
        for (int i = 0; i < 14; i++) begin
            if (tv[i].w != 0) wr_reg(tv[i].a, tv[i].v, tv[i].w);
            rd_reg(tv[i].a, d);
            chk($sformatf("reg_vec%0d", i), d, tv[i].exp);
        end

        wr_reg(3'd1, 32'h55, 4'hf);
        addr = 3'd1; re = 1; we = 4'hf; wdata = 32'hAA;
        cyc(1);
        re = 0; we = 0;
        chk("rd_wr_same_cycle_old", rdata, 32'h55);
        rd_reg(3'd1, d);
        chk("rd_wr_same_cycle_new", d, 32'hAA);

        reset_dut();
        wr_reg(3'd1, 32'h8, 4'hf);
        wr_reg(3'd2, 32'h8, 4'hf);
        src[3] = 1;
        cyc(1);
        src[3] = 0;
        cyc(1);
        chk("edge3_not_yet", int_pending, 0);
        cyc(1);
        chk("edge3_pending", int_pending, 1);
        chk("edge3_type", int_type, 3);
        rd_reg(3'd4, d);
        chk("current_read", d, 32'h8000_0003);
        ack();
        chk("edge3_acked", int_pending, 0);
        rd_reg(3'd0, d);
        chk("edge3_status", d, 0);
        rd_reg(3'd6, d);
        chk("addr6_read", d, 0);
        cyc(2);
        chk("edge3_no_repeat", int_pending, 0);

        reset_dut();
        wr_reg(3'd1, 32'h24, 4'hf);
        wr_reg(3'd2, 32'h24, 4'hf);
        pulse(16'h24);
        cyc(2);
        chk("pair_first_pending", int_pending, 1);
        chk("pair_first_type", int_type, 2);
        ack();
        chk("pair_ack_bubble", int_pending, 0);
        cyc(1);
        chk("pair_idle", int_pending, 0);
        cyc(1);
        chk("pair_second_pending", int_pending, 1);
        chk("pair_second_type", int_type, 5);
        ack();
        cyc(3);
        chk("pair_done", int_pending, 0);

        reset_dut();
        wr_reg(3'd1, 32'h2, 4'hf);
        src = 16'h2;
        cyc(3);
        chk("level_pending", int_pending, 1);
        chk("level_type", int_type, 1);
        ack();
        chk("level_ack", int_pending, 0);
        cyc(1);
        chk("level_bubble", int_pending, 0);
        cyc(1);
        chk("level_represent", int_pending, 1);
        src = 0;
        cyc(2);
        chk("level_still_held", int_pending, 1);
        cyc(1);
        chk("level_withdraw", int_pending, 0);

        reset_dut();
        wr_reg(3'd1, 32'h80, 4'hf);
        wr_reg(3'd2, 32'h80, 4'hf);
        pulse(16'h80);
        cyc(2);
        chk("src7_type", int_type, 7);
        wr_reg(3'd1, 32'h0, 4'hf);
        chk("src7_write_cycle", int_pending, 1);
        cyc(1);
        chk("src7_masked", int_pending, 0);
        wr_reg(3'd1, 32'h80, 4'hf);
        cyc(1);
        chk("src7_reenabled", int_pending, 1);
        addr = 3'd1; we = 4'hf; wdata = 0; clr = 1;
        cyc(1);
        we = 0; clr = 0;
        chk("src7_clear_beats_withdraw", int_pending, 0);
        rd_reg(3'd0, d);
        chk("src7_bit_cleared", d, 0);
        wr_reg(3'd1, 32'h80, 4'hf);
        cyc(2);
        chk("src7_gone", int_pending, 0);

        reset_dut();
        wr_reg(3'd2, 32'h10, 4'hf);
        pulse(16'h10);
        cyc(4);
        rd_reg(3'd0, d);
        chk("src4_latched", d, 32'h10);
        src[4] = 1;
        cyc(1);
        src[4] = 0;
        cyc(1);
        addr = 3'd3; we = 4'hf; wdata = 32'h10;
        cyc(1);
        we = 0;
        rd_reg(3'd0, d);
        chk("src4_set_wins", d, 32'h10);
        wr_reg(3'd3, 32'h10, 4'hf);
        rd_reg(3'd0, d);
        chk("src4_cleared", d, 0);

        reset_dut();
        wr_reg(3'd1, 32'h2, 4'hf);
        src = 16'h2;
        cyc(3);
        chk("rst_pre_pending", int_pending, 1);
        rst = 1;
        cyc(1);
        rst = 0;
        chk("rst_drop_pending", int_pending, 0);
        rd_reg(3'd0, d);
        chk("rst_status", d, 0);
        rd_reg(3'd1, d);
        chk("rst_enable", d, 0);
        cyc(5);
        chk("rst_no_represent", int_pending, 0);

        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) src = src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            addr  = 3'($urandom_range(0, 7));
            we    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            wdata = $urandom;
            re    = $urandom_range(0, 1) == 1;
            clr   = $urandom_range(0, 3) == 0;
            rst   = $urandom_range(0, 799) == 0;
            cyc(1);
        end
        src = 0; we = 0; re = 0; clr = 0; rst = 0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
